// File: rtl/alarm_time_setter.sv
// Button-driven editor for the watch time preset and the alarm time.
// Four buttons are synchronized and edge-detected. A small FSM then walks the
// digits HD/HO/MD/MO of a working copy. On commit the working copy is written
// to the time preset (with a time_load pulse) or to the alarm digits.

// Per-button conditioner: SYNC_STAGES-flop synchronizer plus rising-edge detect.
module alarm_btn_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn,
  output logic press
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the raw level in and remember the last synchronized level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign press = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

module alarm_time_setter #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 500_000_000,
  parameter int TO_W        = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        btn_mode,
  input  logic        btn_next,
  input  logic        btn_inc,
  input  logic        btn_alarm,
  input  logic        sel_alarm,
  output logic [3:0]  hourdec_init,
  output logic [3:0]  hourone_init,
  output logic [3:0]  mindec_init,
  output logic [3:0]  minone_init,
  output logic        time_load,
  output logic [3:0]  hourdec_bud,
  output logic [3:0]  hourone_bud,
  output logic [3:0]  mindec_bud,
  output logic [3:0]  minone_bud,
  output logic        bud_en,
  output logic        edit_active,
  output logic [3:0]  edit_digit,
  output logic [15:0] edit_val
);
  localparam int NUM_BTN = 4;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HD   = 3'd1;
  localparam logic [2:0] S_HO   = 3'd2;
  localparam logic [2:0] S_MD   = 3'd3;
  localparam logic [2:0] S_MO   = 3'd4;

  // Digit sets are packed as [3]=HD, [2]=HO, [1]=MD, [0]=MO.
  logic [3:0][3:0]     tim_q, alm_q, wc_q, wc_inc;
  logic [2:0]          state_q;
  logic                tgt_alarm_q;
  logic [TO_W-1:0]     to_cnt;
  logic                to_hit, in_edit;

  logic [NUM_BTN-1:0]  btn_raw, press;
  logic                p_mode, p_next, p_inc, p_alarm;

  assign btn_raw = {btn_alarm, btn_inc, btn_next, btn_mode};

  alarm_btn_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync [NUM_BTN-1:0] (
    .clk   (clk),
    .rstn  (rstn),
    .btn   (btn_raw),
    .press (press)
  );

  // One press per cycle: mode beats next beats inc; alarm only matters in IDLE.
  assign p_mode  = press[0];
  assign p_next  = press[1] & ~press[0];
  assign p_inc   = press[2] & ~press[1] & ~press[0];
  assign p_alarm = press[3] & ~press[0];

  assign in_edit = (state_q >= S_HD) && (state_q <= S_MO);
  assign to_hit  = (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  // Increment of the selected digit with wrap; raising HD to 2 clamps HO to 3.
  always_comb begin
    wc_inc = wc_q;
    case (state_q)
      S_HD: begin
        wc_inc[3] = (wc_q[3] >= 4'd2) ? 4'd0 : wc_q[3] + 4'd1;
        if (wc_inc[3] == 4'd2 && wc_q[2] > 4'd3) wc_inc[2] = 4'd3;
      end
      S_HO: begin
        if (wc_q[3] == 4'd2) wc_inc[2] = (wc_q[2] >= 4'd3) ? 4'd0 : wc_q[2] + 4'd1;
        else                 wc_inc[2] = (wc_q[2] >= 4'd9) ? 4'd0 : wc_q[2] + 4'd1;
      end
      S_MD: wc_inc[1] = (wc_q[1] >= 4'd5) ? 4'd0 : wc_q[1] + 4'd1;
      S_MO: wc_inc[0] = (wc_q[0] >= 4'd9) ? 4'd0 : wc_q[0] + 4'd1;
      default: ;
    endcase
  end

  // Edit FSM, working copy and idle timeout.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      tgt_alarm_q <= 1'b0;
      wc_q        <= '0;
      to_cnt      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (p_mode) begin
            state_q     <= S_HD;
            tgt_alarm_q <= sel_alarm;
            wc_q        <= sel_alarm ? alm_q : tim_q;
            to_cnt      <= '0;
          end
        end
        S_HD, S_HO, S_MD, S_MO: begin
          if (p_mode) begin
            state_q <= S_IDLE;
          end else if (p_next) begin
            state_q <= (state_q == S_MO) ? S_HD : state_q + 3'd1;
            to_cnt  <= '0;
          end else if (p_inc) begin
            wc_q   <= wc_inc;
            to_cnt <= '0;
          end else if (to_hit) begin
            state_q <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Committed digit sets, the time_load pulse and the alarm enable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tim_q     <= '0;
      alm_q     <= '0;
      time_load <= 1'b0;
      bud_en    <= 1'b0;
    end else begin
      time_load <= 1'b0;
      if (in_edit && p_mode) begin
        if (tgt_alarm_q) begin
          alm_q <= wc_q;
        end else begin
          tim_q     <= wc_q;
          time_load <= 1'b1;
        end
      end
      if (state_q == S_IDLE && p_alarm) bud_en <= ~bud_en;
    end
  end

  // One-hot digit indicator for the display.
  always_comb begin
    case (state_q)
      S_HD:    edit_digit = 4'b1000;
      S_HO:    edit_digit = 4'b0100;
      S_MD:    edit_digit = 4'b0010;
      S_MO:    edit_digit = 4'b0001;
      default: edit_digit = 4'b0000;
    endcase
  end

  assign edit_active = in_edit;
  assign edit_val    = wc_q;
  assign {hourdec_init, hourone_init, mindec_init, minone_init} = tim_q;
  assign {hourdec_bud,  hourone_bud,  mindec_bud,  minone_bud}  = alm_q;
endmodule

// File: tb/tb_alarm_time_setter.sv
// Bench for alarm_time_setter: a table of button presses with expected edit
// state, hand-written corner sequences, and a random phase. A cycle-level
// reference model (press = delayed rising edge, digits as integers) is
// compared against every output after every clock.
module tb_alarm_time_setter;
  localparam int S  = 2;
  localparam int TO = 100;

  localparam logic [3:0] B_MODE = 4'b0001;
  localparam logic [3:0] B_NEXT = 4'b0010;
  localparam logic [3:0] B_INC  = 4'b0100;
  localparam logic [3:0] B_ALM  = 4'b1000;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  btns;
  logic        sel;
  logic [3:0]  hourdec_init, hourone_init, mindec_init, minone_init;
  logic [3:0]  hourdec_bud, hourone_bud, mindec_bud, minone_bud;
  logic        time_load, bud_en, edit_active;
  logic [3:0]  edit_digit;
  logic [15:0] edit_val;

  alarm_time_setter #(.SYNC_STAGES(S), .TIMEOUT_CYC(TO), .TO_W(8)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .btn_mode     (btns[0]),
    .btn_next     (btns[1]),
    .btn_inc      (btns[2]),
    .btn_alarm    (btns[3]),
    .sel_alarm    (sel),
    .hourdec_init (hourdec_init),
    .hourone_init (hourone_init),
    .mindec_init  (mindec_init),
    .minone_init  (minone_init),
    .time_load    (time_load),
    .hourdec_bud  (hourdec_bud),
    .hourone_bud  (hourone_bud),
    .mindec_bud   (mindec_bud),
    .minone_bud   (minone_bud),
    .bud_en       (bud_en),
    .edit_active  (edit_active),
    .edit_digit   (edit_digit),
    .edit_val     (edit_val)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int tl_cnt = 0;

  // Reference model state: digits index 0=HD, 1=HO, 2=MD, 3=MO.
  logic [3:0] h [0:S+1];
  bit  m_edit, m_tgt, m_bud, m_load;
  int  m_pos, m_to;
  int  m_time [4];
  int  m_alm  [4];
  int  m_wc   [4];

  typedef struct {
    logic [3:0]  btn;
    logic        sel;
    logic        act;
    logic [3:0]  dig;
    logic [15:0] val;
    logic        bud;
  } vec_t;
  vec_t vt[$];

  function automatic logic [15:0] pack(input int a[4]);
    return {4'(a[0]), 4'(a[1]), 4'(a[2]), 4'(a[3])};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i <= S + 1; i++) h[i] = 4'b0;
    m_edit = 0; m_tgt = 0; m_bud = 0; m_load = 0; m_pos = 0; m_to = 0;
    for (int k = 0; k < 4; k++) begin m_time[k] = 0; m_alm[k] = 0; m_wc[k] = 0; end
  endtask

  // One clock of the specification's behaviour, given the levels just sampled.
  task automatic model_step(input logic [3:0] raw, input logic s);
    logic [3:0] pr;
    for (int i = S + 1; i > 0; i--) h[i] = h[i-1];
    h[0] = raw;
    pr = h[S] & ~h[S+1];
    m_load = 0;
    if (!m_edit) begin
      if (pr[0]) begin
        m_edit = 1; m_pos = 0; m_tgt = s; m_to = 0;
        for (int k = 0; k < 4; k++) m_wc[k] = s ? m_alm[k] : m_time[k];
      end else if (pr[3]) begin
        m_bud = !m_bud;
      end
    end else if (pr[0]) begin
      for (int k = 0; k < 4; k++) begin
        if (m_tgt) m_alm[k] = m_wc[k]; else m_time[k] = m_wc[k];
      end
      m_load = !m_tgt;
      m_edit = 0;
    end else if (pr[1]) begin
      m_pos = (m_pos + 1) % 4; m_to = 0;
    end else if (pr[2]) begin
      m_to = 0;
      case (m_pos)
        0: begin
          m_wc[0] = (m_wc[0] + 1) % 3;
          if (m_wc[0] == 2 && m_wc[1] > 3) m_wc[1] = 3;
        end
        1: m_wc[1] = (m_wc[1] + 1) % ((m_wc[0] == 2) ? 4 : 10);
        2: m_wc[2] = (m_wc[2] + 1) % 6;
        default: m_wc[3] = (m_wc[3] + 1) % 10;
      endcase
    end else if (m_to == TO - 1) begin
      m_edit = 0;
    end else begin
      m_to++;
    end
  endtask

  task automatic compare_all();
    logic [3:0] one;
    one = 4'b1000;
    check("init", {hourdec_init, hourone_init, mindec_init, minone_init}, pack(m_time));
    check("bud", {hourdec_bud, hourone_bud, mindec_bud, minone_bud}, pack(m_alm));
    check("bud_en", bud_en, m_bud);
    check("time_load", time_load, m_load);
    check("edit_active", edit_active, m_edit);
    check("edit_digit", edit_digit, m_edit ? (one >> m_pos) : 4'b0);
    if (m_edit) check("edit_val", edit_val, pack(m_wc));
    if (time_load) tl_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(btns, sel);
    @(negedge clk);
    compare_all();
  endtask

  task automatic press(input logic [3:0] b);
    btns = b;
    tick();
    btns = 4'b0;
    repeat (3) tick();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    btns = 4'b0;
    #1;
    model_reset();
    compare_all();
    check("rst_init", {hourdec_init, hourone_init, mindec_init, minone_init}, 16'h0000);
    check("rst_bud", {hourdec_bud, hourone_bud, mindec_bud, minone_bud}, 16'h0000);
    check("rst_flags", {bud_en, edit_active, time_load, edit_digit}, 7'b0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic add(input logic [3:0] b, input logic s, input logic a,
                     input logic [3:0] d, input logic [15:0] v, input logic bu);
    vec_t x;
    x.btn = b; x.sel = s; x.act = a; x.dig = d; x.val = v; x.bud = bu;
    vt.push_back(x);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_t2;
    int n;
    rstn = 1'b0; btns = 4'b0; sel = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Time 23:59 (sel=0), then alarm 07:30 (sel=1), then bud_en toggles.
    add(B_MODE, 0, 1, 4'b1000, 16'h0000, 0);
    add(B_INC,  0, 1, 4'b1000, 16'h1000, 0);
    add(B_INC,  0, 1, 4'b1000, 16'h2000, 0);
    add(B_NEXT, 0, 1, 4'b0100, 16'h2000, 0);
    for (int i = 1; i <= 3; i++) add(B_INC, 0, 1, 4'b0100, 16'(16'h2000 + i * 16'h100), 0);
    add(B_NEXT, 0, 1, 4'b0010, 16'h2300, 0);
    for (int i = 1; i <= 5; i++) add(B_INC, 0, 1, 4'b0010, 16'(16'h2300 + i * 16'h10), 0);
    add(B_NEXT, 0, 1, 4'b0001, 16'h2350, 0);
    for (int i = 1; i <= 9; i++) add(B_INC, 0, 1, 4'b0001, 16'(16'h2350 + i), 0);
    add(B_MODE, 0, 0, 4'b0000, 16'h0000, 0);
    n_t2 = vt.size();
    add(B_MODE, 1, 1, 4'b1000, 16'h0000, 0);
    add(B_NEXT, 1, 1, 4'b0100, 16'h0000, 0);
    for (int i = 1; i <= 7; i++) add(B_INC, 1, 1, 4'b0100, 16'(i * 16'h100), 0);
    add(B_NEXT, 1, 1, 4'b0010, 16'h0700, 0);
    for (int i = 1; i <= 3; i++) add(B_INC, 1, 1, 4'b0010, 16'(16'h0700 + i * 16'h10), 0);
    add(B_MODE, 1, 0, 4'b0000, 16'h0000, 0);
    add(B_ALM,  0, 0, 4'b0000, 16'h0000, 1);
    add(B_ALM,  0, 0, 4'b0000, 16'h0000, 0);

    foreach (vt[i]) begin
      sel = vt[i].sel;
      press(vt[i].btn);
      check("vec_act", edit_active, vt[i].act);
      check("vec_dig", edit_digit, vt[i].dig);
      if (vt[i].act) check("vec_val", edit_val, vt[i].val);
      check("vec_bud_en", bud_en, vt[i].bud);
      if (i == n_t2 - 1) begin
        check("t2_init", {hourdec_init, hourone_init, mindec_init, minone_init}, 16'h2359);
        check("t2_bud", {hourdec_bud, hourone_bud, mindec_bud, minone_bud}, 16'h0000);
        check("t2_load_cnt", tl_cnt, 1);
      end
    end
    check("t4_bud", {hourdec_bud, hourone_bud, mindec_bud, minone_bud}, 16'h0730);
    check("t4_init", {hourdec_init, hourone_init, mindec_init, minone_init}, 16'h2359);
    check("t4_load_cnt", tl_cnt, 1);

    // Mode and inc rise together in E_MO: commit only, MO stays 9.
    sel = 1'b0;
    press(B_MODE);
    repeat (3) press(B_NEXT);
    check("t6_dig", edit_digit, 4'b0001);
    btns = B_MODE | B_INC;
    tick();
    btns = 4'b0;
    repeat (3) tick();
    check("t6_act", edit_active, 1'b0);
    check("t6_init", {hourdec_init, hourone_init, mindec_init, minone_init}, 16'h2359);
    check("t6_load_cnt", tl_cnt, 2);

    // A held inc counts once: HD 2 -> 0.
    press(B_MODE);
    btns = B_INC;
    repeat (20) tick();
    btns = 4'b0;
    repeat (3) tick();
    check("held_val", edit_val, 16'h0359);
    press(B_MODE);
    check("held_init", {hourdec_init, hourone_init, mindec_init, minone_init}, 16'h0359);
    check("held_load_cnt", tl_cnt, 3);

    // Timeout: the inc is acted on at the third edge, then 100 idle edges.
    press(B_MODE);
    btns = B_INC;
    tick();
    btns = 4'b0;
    tick();
    tick();
    check("to_val", edit_val, 16'h1359);
    n = 0;
    while (edit_active && n < 200) begin
      tick();
      n++;
    end
    check("to_cycles", n, 100);
    check("to_init", {hourdec_init, hourone_init, mindec_init, minone_init}, 16'h0359);
    check("to_bud", {hourdec_bud, hourone_bud, mindec_bud, minone_bud}, 16'h0730);
    check("to_load_cnt", tl_cnt, 3);

    // Clamp: 19:59 -> HD inc -> 23:59, then HO inc from 3 -> 0.
    press(B_MODE);
    press(B_INC);
    press(B_NEXT);
    repeat (6) press(B_INC);
    check("clamp_pre", edit_val, 16'h1959);
    repeat (3) press(B_NEXT);
    check("clamp_dig", edit_digit, 4'b1000);
    press(B_INC);
    check("clamp_val", edit_val, 16'h2359);
    press(B_NEXT);
    press(B_INC);
    check("clamp_wrap", edit_val, 16'h2059);

    // Reset in the middle of that edit.
    do_reset();
    repeat (5) tick();
    check("t1_act", edit_active, 1'b0);
    check("t1_init", {hourdec_init, hourone_init, mindec_init, minone_init}, 16'h0000);
    check("t1_load_cnt", tl_cnt, 3);

    // Random buttons with quiet windows long enough to reach the timeout.
    for (int c = 0; c < 4000; c++) begin
      if ((c % 600) < 450) begin
        for (int b = 0; b < 4; b++) btns[b] = ($urandom_range(0, 7) == 0);
        sel = 1'($urandom_range(0, 1));
      end else begin
        btns = 4'b0;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
